// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte-wide requesters, with a done watchdog.
// Optional feature: define UART_ARB_BURST_EN to let a grant send up to MAX_BURST consecutive bytes.
module uart_tx_arbiter #(
    parameter int N         = 4,
    parameter int IDW       = 2,
    parameter int TIMEOUT   = 65535,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [8*N-1:0]   req_data,
    output logic [N-1:0]     ack,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_done,
    output logic [IDW-1:0]   grant_id,
    output logic             busy,
    output logic             timeout
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    generate
        if (N < 2 || N > 8 || IDW != $clog2(N) || MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_params
            $error("uart_tx_arbiter: illegal parameter combination");
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [N-1:0]     ack_reg, ack_next;
    logic             tx_start_reg, tx_start_next;
    logic [7:0]       tx_data_reg, tx_data_next;
    logic [IDW-1:0]   grant_id_reg, grant_id_next;
    logic             busy_reg, busy_next;
    logic             timeout_reg, timeout_next;
    logic [IDW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [WDW-1:0]   watchdog_reg, watchdog_next;
    logic [IDW-1:0]   rr_adv;
    logic [IDW-1:0]   sel;
    logic             found;
    logic [7:0]       req_byte [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bytes
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

`ifdef UART_ARB_BURST_EN
    localparam int BCW = $clog2(MAX_BURST + 1);
    logic [BCW-1:0] burst_cnt_reg, burst_cnt_next;
`endif

    // First requesting index at or after rr_ptr, wrapping modulo N.
    always_comb begin
        int idx;
        logic [IDW-1:0] cand;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= N) idx = idx - N;
            cand = IDW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign rr_adv = (grant_id_reg == IDW'(N - 1)) ? '0 : grant_id_reg + 1'b1;

    always_comb begin
        state_next    = state_reg;
        ack_next      = '0;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data_reg;
        grant_id_next = grant_id_reg;
        timeout_next  = timeout_reg;
        rr_ptr_next   = rr_ptr_reg;
        watchdog_next = watchdog_reg;
`ifdef UART_ARB_BURST_EN
        burst_cnt_next = burst_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (found) begin
                    grant_id_next = sel;
                    tx_data_next  = req_byte[sel];
                    tx_start_next = 1'b1;
                    ack_next[sel] = 1'b1;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                watchdog_next = '0;
                state_next    = WAIT_DONE;
            end
            WAIT_DONE: begin
                // tx_done takes priority over a watchdog expiry in the same cycle.
                if (tx_done) begin
`ifdef UART_ARB_BURST_EN
                    if (req[grant_id_reg] && burst_cnt_reg < BCW'(MAX_BURST - 1)) begin
                        burst_cnt_next         = burst_cnt_reg + 1'b1;
                        tx_data_next           = req_byte[grant_id_reg];
                        tx_start_next          = 1'b1;
                        ack_next[grant_id_reg] = 1'b1;
                        state_next             = ISSUE;
                    end else begin
                        burst_cnt_next = '0;
                        rr_ptr_next    = rr_adv;
                        state_next     = IDLE;
                    end
`else
                    rr_ptr_next = rr_adv;
                    state_next  = IDLE;
`endif
                end else if (watchdog_reg == WDW'(TIMEOUT)) begin
                    timeout_next = 1'b1;
                    rr_ptr_next  = rr_adv;
                    state_next   = IDLE;
`ifdef UART_ARB_BURST_EN
                    burst_cnt_next = '0;
`endif
                end else begin
                    watchdog_next = watchdog_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ack_reg      <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            grant_id_reg <= '0;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            rr_ptr_reg   <= '0;
            watchdog_reg <= '0;
`ifdef UART_ARB_BURST_EN
            burst_cnt_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            ack_reg      <= ack_next;
            tx_start_reg <= tx_start_next;
            tx_data_reg  <= tx_data_next;
            grant_id_reg <= grant_id_next;
            busy_reg     <= busy_next;
            timeout_reg  <= timeout_next;
            rr_ptr_reg   <= rr_ptr_next;
            watchdog_reg <= watchdog_next;
`ifdef UART_ARB_BURST_EN
            burst_cnt_reg <= burst_cnt_next;
`endif
        end
    end

    assign ack      = ack_reg;
    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
    assign grant_id = grant_id_reg;
    assign busy     = busy_reg;
    assign timeout  = timeout_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: latency, round-robin order, wrap, watchdog, async reset.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int IDW = 2;
    localparam int TIMEOUT = 100;
    localparam int MAX_BURST = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout;

    int total = 0;
    int bad = 0;

    uart_tx_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (tx_start) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic pulse_done;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        req = '0; req_data = '0; tx_done = 1'b0; rst = 1'b1;
        #1;
        total++;
        if ({ack, tx_start, tx_data, grant_id, busy, timeout} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0000", {ack, tx_start, tx_data, grant_id, busy, timeout});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single;
        req_data[7:0] = 8'h55; req = 4'b0001;
        @(negedge clk);
        total++;
        if ({tx_start, tx_data, ack, busy, grant_id} !== {1'b1, 8'h55, 4'b0001, 1'b1, 2'd0}) begin
            bad++;
            $display("FAIL single_issue: got %h expected %h", {tx_start, tx_data, ack, busy, grant_id}, {1'b1, 8'h55, 4'b0001, 1'b1, 2'd0});
        end
        req = '0;
        @(negedge clk);
        total++;
        if ({tx_start, ack, busy, tx_data} !== {1'b0, 4'b0000, 1'b1, 8'h55}) begin
            bad++;
            $display("FAIL single_wait: got %h expected %h", {tx_start, ack, busy, tx_data}, {1'b0, 4'b0000, 1'b1, 8'h55});
        end
        pulse_done();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL single_done_busy: got %b expected 0", busy);
        end
        pulse_done();
        total++;
        if ({busy, tx_start} !== 2'b00) begin
            bad++; $display("FAIL idle_done_ignored: got %b expected 00", {busy, tx_start});
        end
        $display("test_single done");
    endtask

    task automatic test_round_robin;
        bit found;
        logic [IDW-1:0] eg;
        logic [N-1:0] ea;
        logic [7:0] ed;
        do_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            eg = IDW'(k % 4);
            ea = 4'b0001 << (k % 4);
            ed = 8'hA0 + 8'(k % 4);
            wait_start(found);
            total++;
            if (!found) begin
                bad++; $display("FAIL rr_start_%0d: got no tx_start expected tx_start", k);
            end
            total++;
            if ({grant_id, ack, tx_data} !== {eg, ea, ed}) begin
                bad++;
                $display("FAIL rr_grant_%0d: got %h expected %h", k, {grant_id, ack, tx_data}, {eg, ea, ed});
            end
            @(negedge clk);
            total++;
            if (ack !== 4'b0000) begin
                bad++; $display("FAIL rr_ack_once_%0d: got %b expected 0000", k, ack);
            end
            if (k == 4) req = '0;
            pulse_done();
            $display("rr byte %0d grant=%0d data=%h", k, eg, ed);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        bit found;
        do_reset();
        req_data = {8'h13, 8'h22, 8'h00, 8'h10}; req = 4'b0100;
        wait_start(found);
        total++;
        if (!found || grant_id !== 2'd2) begin
            bad++; $display("FAIL wrap_pre: got %0d expected 2", grant_id);
        end
        req = '0;
        @(negedge clk);
        pulse_done();
        req = 4'b1001;
        wait_start(found);
        total++;
        if (!found || {grant_id, tx_data} !== {2'd3, 8'h13}) begin
            bad++; $display("FAIL wrap_first: got %h expected %h", {grant_id, tx_data}, {2'd3, 8'h13});
        end
        @(negedge clk);
        pulse_done();
        wait_start(found);
        total++;
        if (!found || {grant_id, tx_data} !== {2'd0, 8'h10}) begin
            bad++; $display("FAIL wrap_second: got %h expected %h", {grant_id, tx_data}, {2'd0, 8'h10});
        end
        req = '0;
        @(negedge clk);
        pulse_done();
        $display("test_wrap done");
    endtask

    task automatic test_done_at_limit;
        bit found;
        do_reset();
        req_data[7:0] = 8'h31; req = 4'b0001;
        wait_start(found);
        req = '0;
        repeat (101) @(negedge clk);
        pulse_done();
        total++;
        if (!found || {busy, timeout} !== 2'b00) begin
            bad++; $display("FAIL done_at_limit: got busy,timeout=%b expected 00", {busy, timeout});
        end
        $display("test_done_at_limit done");
    endtask

    task automatic test_timeout;
        bit found;
        int cycles;
        do_reset();
        req_data[15:8] = 8'h77; req = 4'b0010;
        wait_start(found);
        req = '0;
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cycles++;
            if (timeout) break;
        end
        total++;
        if (!found || timeout !== 1'b1 || cycles != 102) begin
            bad++; $display("FAIL timeout_set: got timeout=%b after %0d cycles expected 1 after 102", timeout, cycles);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL timeout_idle: got busy=%b expected 0", busy);
        end
        req_data[23:8] = {8'h62, 8'h61}; req = 4'b0110;
        wait_start(found);
        total++;
        if (!found || {grant_id, tx_data} !== {2'd2, 8'h62}) begin
            bad++; $display("FAIL timeout_next_grant: got %h expected %h", {grant_id, tx_data}, {2'd2, 8'h62});
        end
        req = '0;
        @(negedge clk);
        pulse_done();
        total++;
        if (timeout !== 1'b1) begin
            bad++; $display("FAIL timeout_sticky: got %b expected 1", timeout);
        end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid;
        bit found;
        req_data[31:24] = 8'hC3; req = 4'b1000;
        wait_start(found);
        req = '0;
        @(negedge clk);
        total++;
        if (!found || {busy, tx_data} !== {1'b1, 8'hC3}) begin
            bad++; $display("FAIL mid_pre: got %h expected %h", {busy, tx_data}, {1'b1, 8'hC3});
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ack, tx_start, tx_data, grant_id, busy, timeout} !== 16'h0000) begin
            bad++;
            $display("FAIL mid_async_reset: got %h expected 0000", {ack, tx_start, tx_data, grant_id, busy, timeout});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL mid_after_reset: got busy=%b expected 0", busy);
        end
        $display("test_reset_mid done");
    endtask

`ifdef UART_ARB_BURST_EN
    task automatic test_burst;
        bit found;
        logic [7:0] ed;
        do_reset();
        req_data = {8'h00, 8'h00, 8'hB1, 8'h01}; req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            ed = 8'(k + 1);
            wait_start(found);
            total++;
            if (!found || {grant_id, tx_data} !== {2'd0, ed}) begin
                bad++; $display("FAIL burst_%0d: got %h expected %h", k, {grant_id, tx_data}, {2'd0, ed});
            end
            req_data[7:0] = 8'(k + 2);
            @(negedge clk);
            pulse_done();
            $display("burst byte %0d data=%h", k, ed);
        end
        wait_start(found);
        total++;
        if (!found || {grant_id, tx_data} !== {2'd1, 8'hB1}) begin
            bad++; $display("FAIL burst_rotate: got %h expected %h", {grant_id, tx_data}, {2'd1, 8'hB1});
        end
        req = '0;
        @(negedge clk);
        pulse_done();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_done_at_limit();
        test_timeout();
        test_reset_mid();
`ifdef UART_ARB_BURST_EN
        test_burst();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
